// File: rtl/bcd_scan_counter.sv
// Two-digit prescaled BCD up/down counter (00-99) with load, enable and wrap pulse.
// Digits are time-multiplexed onto one BCD nibble (W..Z) with a one-hot digit select.
module bcd_scan_counter #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic [1:0] dig_sel,
  output logic [7:0] count,
  output logic       wrap
);

  localparam int unsigned PW = 26;
  localparam int unsigned SW = 20;
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          sel_q, sel_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    disp_q, disp_d;
  logic [1:0]    dig_sel_q, dig_sel_d;
  logic          wrap_q, wrap_d;
  logic          step_c;
  logic          scan_wrap_c;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Prescaler and digit update: load > step > hold.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    wrap_d    = 1'b0;
    step_c    = en && (pre_cnt_q == PRE_MAX);
    if (load) begin
      tens_d    = clamp9(load_val[7:4]);
      ones_d    = clamp9(load_val[3:0]);
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = step_c ? '0 : pre_cnt_q + PW'(1);
      if (step_c) begin
        if (up) begin
          if (ones_q < 4'd9) begin
            ones_d = ones_q + 4'd1;
          end else begin
            ones_d = 4'd0;
            if (tens_q == 4'd9) begin
              tens_d = 4'd0;
              wrap_d = 1'b1;
            end else begin
              tens_d = tens_q + 4'd1;
            end
          end
        end else begin
          if (ones_q > 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            if (tens_q == 4'd0) begin
              tens_d = 4'd9;
              wrap_d = 1'b1;
            end else begin
              tens_d = tens_q - 4'd1;
            end
          end
        end
      end
    end
  end

  // Free-running scan timer and registered display mux.
  always_comb begin
    scan_wrap_c = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d  = scan_wrap_c ? '0 : scan_cnt_q + SW'(1);
    sel_d       = sel_q ^ scan_wrap_c;
    disp_d      = sel_q ? tens_q : ones_q;
    dig_sel_d   = sel_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      scan_cnt_q <= '0;
      sel_q      <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      disp_q     <= 4'd0;
      dig_sel_q  <= 2'b01;
      wrap_q     <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      disp_q     <= disp_d;
      dig_sel_q  <= dig_sel_d;
      wrap_q     <= wrap_d;
    end
  end

  assign {Z, Y, X, W} = disp_q;
  assign dig_sel      = dig_sel_q;
  assign count        = {tens_q, ones_q};
  assign wrap         = wrap_q;

endmodule
